// File: rtl/io_filter_sync.sv
// GPIO pad front end: per-pin synchroniser and glitch filter, runtime pin-order
// mapping, change-event handshake towards the core and a masked output write port.
module io_filter_sync #(
  parameter int IO_PINS     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rev,
  input  logic [IO_PINS-1:0] pin_dir,
  input  logic [IO_PINS-1:0] pin_data_in,
  output logic [IO_PINS-1:0] pin_data_out,
  output logic [IO_PINS-1:0] in_data,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [IO_PINS-1:0] ev_mask,
  output logic [IO_PINS-1:0] ev_data,
  input  logic               out_we,
  input  logic [IO_PINS-1:0] out_mask,
  input  logic [IO_PINS-1:0] out_data
);

  // Port/pin mapping is an involution, so one function converts both ways.
  function automatic logic [IO_PINS-1:0] remap(input logic [IO_PINS-1:0] v, input logic r);
    logic [IO_PINS-1:0] m;
    m = '0;
    for (int i = 0; i < IO_PINS; i++) begin
      if (r) m[i] = v[IO_PINS-1-i];
      else   m[i] = v[i];
    end
    return m;
  endfunction

  logic                rev_q;
  logic [IO_PINS-1:0]  sync_q [SYNC_STAGES];
  logic [IO_PINS-1:0]  st_q, st_nxt;
  logic [CNT_W-1:0]    cnt_q   [IO_PINS];
  logic [CNT_W-1:0]    cnt_nxt [IO_PINS];
  logic [IO_PINS-1:0]  out_q, out_nxt;
  logic [IO_PINS-1:0]  pend_q, pend_nxt;
  logic [IO_PINS-1:0]  chg_pin, chg_port, dir_port;
  logic [IO_PINS-1:0]  wmask_pin, wdata_pin;
  logic [IO_PINS-1:0]  sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_data_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Filter: output pins reload from out_q and never raise a change.
  always_comb begin
    st_nxt  = st_q;
    chg_pin = '0;
    for (int i = 0; i < IO_PINS; i++) cnt_nxt[i] = cnt_q[i];
    for (int i = 0; i < IO_PINS; i++) begin
      if (pin_dir[i]) begin
        st_nxt[i]  = out_q[i];
        cnt_nxt[i] = '0;
      end else if (sync[i] == st_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CNT_W'(FILTER_LEN-1)) begin
        st_nxt[i]  = sync[i];
        cnt_nxt[i] = '0;
        chg_pin[i] = 1'b1;
      end else begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign chg_port  = remap(chg_pin, rev_q);
  assign dir_port  = remap(pin_dir, rev_q);
  assign wmask_pin = remap(out_mask, rev_q);
  assign wdata_pin = remap(out_data, rev_q);

  // Changes landing on the accept edge become the next event rather than being dropped.
  always_comb begin
    pend_nxt = pend_q;
    if (rev != rev_q) begin
      pend_nxt = '0;
    end else if (ev_valid && ev_ready) begin
      pend_nxt = chg_port & ~dir_port;
    end else begin
      pend_nxt = (pend_q | chg_port) & ~dir_port;
    end
  end

  always_comb begin
    out_nxt = out_q;
    if (out_we) begin
      out_nxt = (out_q & ~wmask_pin) | (wdata_pin & wmask_pin);
    end else begin
      out_nxt = out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q  <= 1'b0;
      st_q   <= '0;
      out_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < IO_PINS; i++) cnt_q[i] <= '0;
    end else begin
      rev_q  <= rev;
      st_q   <= st_nxt;
      out_q  <= out_nxt;
      pend_q <= pend_nxt;
      for (int i = 0; i < IO_PINS; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign pin_data_out = out_q;
  assign in_data      = remap(st_q, rev_q);
  assign ev_data      = in_data;
  assign ev_mask      = pend_q;
  assign ev_valid     = |pend_q;

endmodule

// File: tb/tb_io_filter_sync.sv
// Directed and randomized bench for io_filter_sync against a window-based
// behavioural model of the synchroniser, filter, event and output rules.
module tb_io_filter_sync;
  localparam int N  = 16;
  localparam int SS = 2;
  localparam int FL = 3;

  logic         clk = 1'b0;
  logic         rst, rev, ev_ready, out_we, ev_valid;
  logic [N-1:0] pin_dir, pin_data_in, pin_data_out, in_data, ev_mask, ev_data;
  logic [N-1:0] out_mask, out_data;

  io_filter_sync #(.IO_PINS(N), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .rev(rev), .pin_dir(pin_dir), .pin_data_in(pin_data_in),
    .pin_data_out(pin_data_out), .in_data(in_data), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_mask(ev_mask), .ev_data(ev_data), .out_we(out_we),
    .out_mask(out_mask), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: filtered values and output latch in pin order, pending mask in port order.
  logic         m_rev;
  logic [N-1:0] m_out, m_st, m_pend;
  int           last_rst [N];
  logic [N-1:0] pad_hist [$];
  logic [N-1:0] s_hist   [$];
  int           k;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rev  = 1'b0;
    m_out  = '0;
    m_st   = '0;
    m_pend = '0;
    for (int p = 0; p < N; p++) last_rst[p] = -1;
    pad_hist.delete();
    s_hist.delete();
    k = 0;
  endtask

  // A pin accepts a new value once its last FL synchronised samples, all taken
  // after its last reload point, differ from the current filtered value.
  task automatic model_edge();
    logic [N-1:0] s, nst, chg_port, dirp;
    pad_hist.push_back(pin_data_in);
    s = (k >= SS) ? pad_hist[k-SS] : '0;
    s_hist.push_back(s);
    nst = m_st;
    chg_port = '0;
    dirp = '0;
    for (int p = 0; p < N; p++) begin
      int q = m_rev ? N-1-p : p;
      dirp[q] = pin_dir[p];
      if (pin_dir[p]) begin
        nst[p] = m_out[p];
        last_rst[p] = k;
      end else if (k-FL+1 > last_rst[p]) begin
        bit run_ok = 1'b1;
        for (int j = k-FL+1; j <= k; j++) if (s_hist[j][p] == m_st[p]) run_ok = 1'b0;
        if (run_ok) begin
          nst[p] = ~m_st[p];
          chg_port[q] = 1'b1;
          last_rst[p] = k;
        end
      end
    end
    if (rev !== m_rev) m_pend = '0;
    else if (m_pend != '0 && ev_ready) m_pend = chg_port;
    else m_pend = m_pend | chg_port;
    m_pend &= ~dirp;
    if (out_we) begin
      for (int i = 0; i < N; i++) if (out_mask[i]) m_out[m_rev ? N-1-i : i] = out_data[i];
    end
    m_st  = nst;
    m_rev = rev;
    k++;
  endtask

  task automatic check_model();
    logic [N-1:0] exp_in;
    for (int i = 0; i < N; i++) exp_in[i] = m_st[m_rev ? N-1-i : i];
    chk("m_in_data", in_data, exp_in);
    chk("m_ev_data", ev_data, exp_in);
    chk("m_ev_mask", ev_mask, m_pend);
    chk("m_ev_valid", {15'd0, ev_valid}, {15'd0, m_pend != '0});
    chk("m_pin_out", pin_data_out, m_out);
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      if (rst) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
      check_model();
    end
  endtask

  initial begin
    rst = 1'b1; rev = 1'b0; pin_dir = '0; pin_data_in = '0; ev_ready = 1'b0;
    out_we = 1'b0; out_mask = '0; out_data = '0;
    model_reset();
    #1;
    chk("rst_pin_out", pin_data_out, 16'h0000);
    chk("rst_in_data", in_data, 16'h0000);
    chk("rst_ev_valid", {15'd0, ev_valid}, 16'h0000);
    chk("rst_ev_mask", ev_mask, 16'h0000);
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // Straight order, step latency and accept.
    pin_data_in = 16'h0001;
    cycles(4);
    chk("lat_early", {15'd0, ev_valid}, 16'h0000);
    cycles(1);
    chk("lat_in_data", in_data, 16'h0001);
    chk("lat_valid", {15'd0, ev_valid}, 16'h0001);
    chk("lat_mask", ev_mask, 16'h0001);
    ev_ready = 1'b1; cycles(1); ev_ready = 1'b0;
    chk("acc_valid", {15'd0, ev_valid}, 16'h0000);
    pin_data_in = 16'h0000;
    cycles(5);
    chk("fall_mask", ev_mask, 16'h0001);
    ev_ready = 1'b1; cycles(1); ev_ready = 1'b0;

    // Reversed order and mapped output write.
    rev = 1'b1; cycles(1);
    pin_data_in = 16'h0001;
    cycles(5);
    chk("rev_in_data", in_data, 16'h8000);
    chk("rev_mask", ev_mask, 16'h8000);
    ev_ready = 1'b1; cycles(1); ev_ready = 1'b0;
    out_we = 1'b1; out_mask = 16'h0003; out_data = 16'h0003;
    cycles(1);
    out_we = 1'b0;
    chk("rev_pin_out", pin_data_out, 16'hC000);
    rev = 1'b0; cycles(1);
    chk("unrev_in_data", in_data, 16'h0001);

    // Glitch rejection, then a pulse just long enough.
    pin_data_in = 16'h0009; cycles(2);
    pin_data_in = 16'h0001; cycles(6);
    chk("glitch_valid", {15'd0, ev_valid}, 16'h0000);
    chk("glitch_in_data", in_data, 16'h0001);
    pin_data_in = 16'h0009; cycles(3);
    pin_data_in = 16'h0001; cycles(2);
    chk("pulse_mask", ev_mask, 16'h0008);
    chk("pulse_in_data", in_data, 16'h0009);
    ev_ready = 1'b1; cycles(8); ev_ready = 1'b0;
    chk("drain_valid", {15'd0, ev_valid}, 16'h0000);

    // Accumulation, then accept coinciding with a new change.
    pin_data_in = 16'h0003; cycles(2);
    pin_data_in = 16'h0007; cycles(3);
    chk("acc1_mask", ev_mask, 16'h0002);
    cycles(2);
    chk("acc2_mask", ev_mask, 16'h0006);
    pin_data_in = 16'h0027; cycles(4);
    ev_ready = 1'b1; cycles(1); ev_ready = 1'b0;
    chk("coinc_mask", ev_mask, 16'h0020);
    chk("coinc_valid", {15'd0, ev_valid}, 16'h0001);
    ev_ready = 1'b1; cycles(1); ev_ready = 1'b0;

    // Output loopback, then release back to inputs.
    out_we = 1'b1; out_mask = 16'hFFFF; out_data = 16'h0055;
    cycles(1);
    out_we = 1'b0;
    pin_dir = 16'h00FF;
    cycles(1);
    chk("loop_in_data", in_data, 16'h0055);
    chk("loop_valid", {15'd0, ev_valid}, 16'h0000);
    pin_data_in = 16'h0000;
    cycles(4);
    chk("loop_hold_valid", {15'd0, ev_valid}, 16'h0000);
    pin_dir = 16'h0000;
    cycles(2);
    chk("release_early", {15'd0, ev_valid}, 16'h0000);
    cycles(1);
    chk("release_mask", ev_mask, 16'h0055);
    chk("release_in_data", in_data, 16'h0000);

    // Asynchronous reset between edges.
    out_we = 1'b1; out_mask = 16'hFFFF; out_data = 16'hFFFF;
    cycles(1);
    out_we = 1'b0;
    chk("pre_rst_pin_out", pin_data_out, 16'hFFFF);
    chk("pre_rst_valid", {15'd0, ev_valid}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pin_out", pin_data_out, 16'h0000);
    chk("arst_valid", {15'd0, ev_valid}, 16'h0000);
    chk("arst_mask", ev_mask, 16'h0000);
    model_reset();
    cycles(2);
    rst = 1'b0;

    // Randomized traffic checked every cycle against the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 31) == 0) rev = ~rev;
      if ($urandom_range(0, 40) == 0) pin_dir = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) pin_data_in = pin_data_in ^ (N'($urandom) & N'($urandom));
      ev_ready = 1'($urandom_range(0, 1));
      out_we   = ($urandom_range(0, 3) == 0);
      out_mask = N'($urandom);
      out_data = N'($urandom);
      cycles(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
